// File: rtl/regfile_write_arbiter_pkg.sv
// Shared writeback types: the request carried from a producer to the regfile write port.
package regfile_write_arbiter_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_queue.sv
// Small FIFO of writeback requests. Exposes per-entry valid and address so that
// hazard detection can scan every queued destination.
module wb_queue
  import regfile_write_arbiter_pkg::*;
#(
  parameter int p_depth = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic                              pop,
  input  wb_req_t                           push_req,
  output wb_req_t                           head,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(p_depth):0]          count,
  output logic [p_depth-1:0]                ent_vld,
  output logic [p_depth-1:0][4:0]           ent_addr
);

  localparam int PW = $clog2(p_depth);
  localparam int CW = PW + 1;

  wb_req_t         mem_q [p_depth];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   off;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_req;
  end

  always_comb begin
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    off = '0;
    for (int i = 0; i < p_depth; i++) begin
      off         = PW'(i) - rd_ptr_q;
      ent_vld[i]  = CW'(off) < count_q;
      ent_addr[i] = mem_q[i].waddr;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(p_depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Single-owner write port front end: ALU results take priority, load returns are
// queued and forced out after p_max_wait consecutive losses.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int p_depth    = 2,
  parameter int p_max_wait = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_val,
  output logic                        alu_rdy,
  input  logic [4:0]                  alu_waddr,
  input  logic [31:0]                 alu_wdata,
  input  logic                        ld_val,
  output logic                        ld_rdy,
  input  logic [4:0]                  ld_waddr,
  input  logic [31:0]                 ld_wdata,
  output logic                        out_wen,
  output logic [4:0]                  out_waddr,
  output logic [31:0]                 out_wdata,
  input  logic [4:0]                  chk_addr,
  output logic                        chk_hit,
  output logic [$clog2(p_depth):0]    q_count
);

  localparam int SW = $clog2(p_max_wait + 1);

  wb_req_t                  ld_req, alu_req, head, sel_req;
  logic                     full, empty, push, pop, take_alu, starved, sel_vld;
  logic [p_depth-1:0]       ent_vld;
  logic [p_depth-1:0][4:0]  ent_addr;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     out_wen_q, out_wen_d;
  logic [4:0]               out_waddr_q, out_waddr_d;
  logic [31:0]              out_wdata_q, out_wdata_d;
  logic                     q_hit;

  assign ld_req  = '{waddr: ld_waddr, wdata: ld_wdata};
  assign alu_req = '{waddr: alu_waddr, wdata: alu_wdata};

  wb_queue #(.p_depth(p_depth)) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .push_req (ld_req),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (q_count),
    .ent_vld  (ent_vld),
    .ent_addr (ent_addr)
  );

  // Readies look only at registered state so producers never see a val->rdy loop.
  assign starved  = !empty && (starve_q == SW'(p_max_wait));
  assign alu_rdy  = !starved;
  assign ld_rdy   = !full;
  assign push     = ld_val && !full;
  assign take_alu = alu_val && alu_rdy;
  assign pop      = !take_alu && !empty;
  assign sel_req  = take_alu ? alu_req : head;
  assign sel_vld  = take_alu || pop;

  always_comb begin
    out_wen_d   = sel_vld && (sel_req.waddr != REG_ZERO);
    out_waddr_d = out_wen_d ? sel_req.waddr : out_waddr_q;
    out_wdata_d = out_wen_d ? sel_req.wdata : out_wdata_q;
    if (empty || pop)  starve_d = '0;
    else if (!starved) starve_d = starve_q + SW'(1);
    else               starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_q    <= '0;
      out_wen_q   <= 1'b0;
      out_waddr_q <= '0;
      out_wdata_q <= '0;
    end else begin
      starve_q    <= starve_d;
      out_wen_q   <= out_wen_d;
      out_waddr_q <= out_waddr_d;
      out_wdata_q <= out_wdata_d;
    end
  end

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < p_depth; i++) begin
      if (ent_vld[i] && (ent_addr[i] == chk_addr)) q_hit = 1'b1;
    end
  end

  assign chk_hit   = (chk_addr != REG_ZERO) &&
                     (q_hit || (out_wen_q && (out_waddr_q == chk_addr)));
  assign out_wen   = out_wen_q;
  assign out_waddr = out_waddr_q;
  assign out_wdata = out_wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with an in-order scoreboard of expected writes.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_val, alu_rdy, ld_val, ld_rdy;
  logic [4:0]  alu_waddr, ld_waddr, out_waddr, chk_addr;
  logic [31:0] alu_wdata, ld_wdata, out_wdata;
  logic        out_wen, chk_hit;
  logic [1:0]  q_count;

  int checks   = 0;
  int failures = 0;
  logic [36:0] sb[$];

  regfile_write_arbiter #(.p_depth(2), .p_max_wait(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_val   (alu_val),
    .alu_rdy   (alu_rdy),
    .alu_waddr (alu_waddr),
    .alu_wdata (alu_wdata),
    .ld_val    (ld_val),
    .ld_rdy    (ld_rdy),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .out_wen   (out_wen),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata),
    .chk_addr  (chk_addr),
    .chk_hit   (chk_hit),
    .q_count   (q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_val = v; alu_waddr = a; alu_wdata = d;
  endtask

  task automatic drive_ld(input logic v, input logic [4:0] a, input logic [31:0] d);
    ld_val = v; ld_waddr = a; ld_wdata = d;
  endtask

  // Every observed write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && out_wen) begin
      chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("sb_write", {27'd0, out_waddr, out_wdata}, 64'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    chk_addr = 5'd0;
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 32'd0);
    #2;
    chk("rst_q_count", 64'(q_count), 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    chk("rst_out_waddr", 64'(out_waddr), 64'd0);
    chk("rst_out_wdata", 64'(out_wdata), 64'd0);
    chk("rst_ld_rdy", 64'(ld_rdy), 64'd1);
    chk("rst_alu_rdy", 64'(alu_rdy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ALU only
    drive_alu(1'b1, 5'd5, 32'hdeadbeef);
    sb.push_back({5'd5, 32'hdeadbeef});
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("alu_wen_c1", 64'(out_wen), 64'd1);
    chk("alu_waddr_c1", 64'(out_waddr), 64'd5);
    chk("alu_wdata_c1", 64'(out_wdata), 64'hdeadbeef);
    tick();
    chk("alu_wen_c2", 64'(out_wen), 64'd0);
    chk("alu_hold_waddr", 64'(out_waddr), 64'd5);
    chk("alu_sb_drained", 64'(sb.size()), 64'd0);

    // Load queue
    drive_ld(1'b1, 5'd3, 32'h11);
    sb.push_back({5'd3, 32'h11});
    chk("ldq_rdy_c0", 64'(ld_rdy), 64'd1);
    tick();
    chk("ldq_wen_c1", 64'(out_wen), 64'd0);
    chk("ldq_count_c1", 64'(q_count), 64'd1);
    chk("ldq_rdy_c1", 64'(ld_rdy), 64'd1);
    drive_ld(1'b1, 5'd4, 32'h22);
    sb.push_back({5'd4, 32'h22});
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    chk("ldq_wen_c2", 64'(out_wen), 64'd1);
    chk("ldq_waddr_c2", 64'(out_waddr), 64'd3);
    chk("ldq_wdata_c2", 64'(out_wdata), 64'h11);
    chk("ldq_rdy_c2", 64'(ld_rdy), 64'd1);
    tick();
    chk("ldq_waddr_c3", 64'(out_waddr), 64'd4);
    chk("ldq_wdata_c3", 64'(out_wdata), 64'h22);
    chk("ldq_count_c3", 64'(q_count), 64'd0);
    tick();
    chk("ldq_wen_c4", 64'(out_wen), 64'd0);
    chk("ldq_sb_drained", 64'(sb.size()), 64'd0);

    // Full queue and starvation
    chk("stv_alu_rdy_a", 64'(alu_rdy), 64'd1);
    drive_alu(1'b1, 5'd16, 32'h100);
    drive_ld(1'b1, 5'd11, 32'hb0);
    sb.push_back({5'd16, 32'h100});
    tick();
    chk("stv_count_b", 64'(q_count), 64'd1);
    chk("stv_ld_rdy_b", 64'(ld_rdy), 64'd1);
    chk("stv_alu_rdy_b", 64'(alu_rdy), 64'd1);
    drive_alu(1'b1, 5'd17, 32'h101);
    drive_ld(1'b1, 5'd13, 32'hb1);
    sb.push_back({5'd17, 32'h101});
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    chk("stv_count_full", 64'(q_count), 64'd2);
    chk("stv_ld_rdy_full", 64'(ld_rdy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("stv_alu_rdy_wait", 64'(alu_rdy), 64'd1);
      drive_alu(1'b1, 5'(18 + k), 32'h102 + 32'(k));
      sb.push_back({5'(18 + k), 32'h102 + 32'(k)});
      tick();
      chk("stv_ld_rdy_hold", 64'(ld_rdy), 64'd0);
    end
    chk("stv_alu_rdy_starved", 64'(alu_rdy), 64'd0);
    drive_alu(1'b1, 5'd21, 32'h105);
    sb.push_back({5'd11, 32'hb0});
    tick();
    chk("stv_count_after_force", 64'(q_count), 64'd1);
    chk("stv_alu_rdy_cleared", 64'(alu_rdy), 64'd1);
    chk("stv_forced_waddr", 64'(out_waddr), 64'd11);
    sb.push_back({5'd21, 32'h105});
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    sb.push_back({5'd13, 32'hb1});
    tick();
    tick();
    chk("stv_count_end", 64'(q_count), 64'd0);
    chk("stv_sb_drained", 64'(sb.size()), 64'd0);

    // Zero register
    chk_addr = 5'd0;
    drive_ld(1'b1, 5'd7, 32'h77);
    chk("zr_hit_z0", 64'(chk_hit), 64'd0);
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    drive_alu(1'b1, 5'd0, 32'hbad0);
    chk("zr_alu_rdy", 64'(alu_rdy), 64'd1);
    chk("zr_hit_z1", 64'(chk_hit), 64'd0);
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    chk("zr_wen_x0", 64'(out_wen), 64'd0);
    chk("zr_count_z2", 64'(q_count), 64'd1);
    chk("zr_hit_z2", 64'(chk_hit), 64'd0);
    sb.push_back({5'd7, 32'h77});
    tick();
    chk("zr_wen_x7", 64'(out_wen), 64'd1);
    chk("zr_waddr_x7", 64'(out_waddr), 64'd7);
    chk("zr_hit_z3", 64'(chk_hit), 64'd0);
    tick();
    chk("zr_sb_drained", 64'(sb.size()), 64'd0);

    // Pending check
    chk_addr = 5'd9;
    chk("pc_hit_before", 64'(chk_hit), 64'd0);
    drive_ld(1'b1, 5'd9, 32'h99);
    sb.push_back({5'd9, 32'h99});
    tick();
    drive_ld(1'b0, 5'd0, 32'd0);
    chk("pc_hit_queued", 64'(chk_hit), 64'd1);
    tick();
    chk("pc_wen_out", 64'(out_wen), 64'd1);
    chk("pc_hit_out", 64'(chk_hit), 64'd1);
    tick();
    chk("pc_wen_drop", 64'(out_wen), 64'd0);
    chk("pc_hit_after", 64'(chk_hit), 64'd0);
    chk_addr = 5'd0;

    // Reset mid-stream
    drive_alu(1'b1, 5'd23, 32'hd0);
    drive_ld(1'b1, 5'd22, 32'hc0);
    sb.push_back({5'd23, 32'hd0});
    tick();
    drive_alu(1'b1, 5'd24, 32'hd1);
    drive_ld(1'b1, 5'd25, 32'hc1);
    sb.push_back({5'd24, 32'hd1});
    tick();
    drive_alu(1'b0, 5'd0, 32'd0);
    drive_ld(1'b0, 5'd0, 32'd0);
    chk("rm_count_full", 64'(q_count), 64'd2);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("rm_q_count", 64'(q_count), 64'd0);
    chk("rm_out_wen", 64'(out_wen), 64'd0);
    chk("rm_ld_rdy", 64'(ld_rdy), 64'd1);
    chk("rm_out_waddr", 64'(out_waddr), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rm_no_stale_wen", 64'(out_wen), 64'd0);
    end
    chk("rm_count_end", 64'(q_count), 64'd0);
    chk("rm_sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Single-owner front end for the write port of the 32x32 zero-register regfile (1 read / 1 write).
- Merges two writeback sources into one registered write per cycle:
  - ALU results: priority source, valid/ready.
  - Memory load returns: queued in a small FIFO, valid/ready.
- Also reports whether a given register has a write still in flight, so decode can detect hazards.

Parameters:
- p_depth, 2, load-queue entries; power of two, >= 2.
- p_max_wait, 4, consecutive cycles the queue head may lose to the ALU before it is forced out.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, one clock; reset is asynchronous and active-low.
- alu_val, input, 1, ALU writeback request.
- alu_rdy, output, 1, ALU request accepted this cycle.
- alu_waddr, input, 5, ALU destination register.
- alu_wdata, input, 32, ALU result.
- ld_val, input, 1, load-return request.
- ld_rdy, output, 1, load queue can accept.
- ld_waddr, input, 5, load destination register.
- ld_wdata, input, 32, load data.
- out_wen, output, 1, regfile write enable (registered).
- out_waddr, output, 5, regfile write address (registered).
- out_wdata, output, 32, regfile write data (registered).
- chk_addr, input, 5, register to test for a pending write.
- chk_hit, output, 1, a write to chk_addr is queued or on out_*.
- q_count, output, $clog2(p_depth)+1, number of occupied queue entries.

Behaviour:
- Reset (async, reset==0):
  - Queue emptied; q_count=0.
  - out_wen=0, out_waddr=0, out_wdata=0.
  - Starvation counter = 0.
  - Asserting reset mid-operation discards all queued loads; no partial write appears on out_*.
- Ready signals: both depend on registered state only, never on *_val.
  - ld_rdy = (q_count != p_depth). No enqueue-through when full, even if a dequeue occurs that cycle.
  - alu_rdy = !(q_count != 0 && starve == p_max_wait).
- Enqueue: ld_val && ld_rdy pushes {ld_waddr, ld_wdata} at the clock edge.
  - A load arriving into an empty queue is issued no earlier than the following cycle.
- Issue select, once per cycle:
  - If alu_val && alu_rdy: the ALU request is chosen.
  - Otherwise, if q_count != 0: the queue head is chosen and popped.
  - Otherwise: nothing is chosen.
- Output register: at the next edge, out_* loads the chosen request with out_wen=1.
  - If nothing was chosen, out_wen=0 and out_waddr/out_wdata hold their previous values.
- Zero register:
  - A chosen request with waddr==0 is consumed (accepted or popped) but drives out_wen=0.
  - chk_hit is always 0 when chk_addr==0.
- Latency:
  - ALU accepted in cycle n → out_wen=1 in cycle n+1 → regfile updates at the end of n+1.
  - Load accepted in cycle n, queue otherwise empty, no ALU traffic → out_wen=1 in cycle n+2.
- Starvation counter:
  - Increments when the queue is non-empty and the head is not popped.
  - Clears on every pop, and whenever the queue is empty.
  - Saturates at p_max_wait; while saturated, alu_rdy=0 and the head is issued.
- Ordering:
  - Loads issue in FIFO order.
  - Ordering between ALU and load writes to the same register is the producer's responsibility; this block does not reorder or merge.
- chk_hit: combinational OR over valid queue entries plus (out_wen && out_waddr==chk_addr).
- Simultaneous enqueue and pop on the same edge: q_count is unchanged and pointers advance mod p_depth.
- Pointer wrap-around is natural; widths are $clog2(p_depth).

Decomposition:
- Shared package (with the other writeback blocks) holds:
  - typedef wb_req_t = {waddr[4:0], wdata[31:0]}.
  - localparam REG_ZERO = 5'd0.
- One sub-module: wb_queue (parameterised FIFO of wb_req_t).
  - Ports: push, pop, head, full, empty, count.
  - Also exports per-entry valid/addr vectors, which feed chk_hit.

Test Plan:
- Reset mid-stream:
  - Stimulus: 2 loads queued, then reset low for 1 cycle.
  - Required: q_count=0, out_wen=0, ld_rdy=1 immediately (async); no stale write afterwards.
- ALU only:
  - Stimulus: alu_val=1, waddr=5, wdata=32'hdeadbeef in cycle 0.
  - Required: cycle 1 out_wen=1, out_waddr=5, out_wdata=deadbeef; cycle 2 out_wen=0.
- Load queue:
  - Stimulus: loads {3, 32'h11}, {4, 32'h22} in cycles 0-1; no ALU traffic.
  - Required: out_* = 3/0x11 in cycle 2 and 4/0x22 in cycle 3; ld_rdy stays 1 throughout.
- Full queue and starvation (p_depth=2, p_max_wait=4):
  - Stimulus: 2 loads queued, alu_val held high.
  - Required: ld_rdy=0; alu_rdy=1 for 4 cycles, then alu_rdy=0 for 1 cycle while the load head issues; counter clears.
- Zero register:
  - Stimulus: ALU write to x0 plus a queued load to x7.
  - Required: ALU accepted with out_wen=0 next cycle; load to x7 issues the cycle after; chk_addr=0 → chk_hit=0 throughout.
- Pending check:
  - Stimulus: load to x9 queued; chk_addr=9.
  - Required: chk_hit=1 while queued and while on out_*; chk_hit=0 the cycle after out_wen drops.
